// File: rtl/uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : uart_tx
// Purpose : FIFO-buffered UART transmitter; 7/8 data bits, optional even
//           parity, switch-selected bit rate latched per frame.
// Rev     : 1.0
// ============================================================================
module uart_tx #(
    parameter int CLKS_9600   = 5208,
    parameter int CLKS_115200 = 434,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  data_in,
    input  logic                        write_enable,
    input  logic                        SW0,
    input  logic                        SW1,
    input  logic                        SW2,
    output logic                        Tx,
    output logic                        busy,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        drop_err
);
    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam logic [12:0] LAST_SLOW = 13'(CLKS_9600 - 1);
    localparam logic [12:0] LAST_FAST = 13'(CLKS_115200 - 1);
    localparam logic [AW:0] DEPTH_CNT = FIFO_DEPTH[AW:0];

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          full_q, empty_q, drop_q;
    logic          push, pop, load, bit_end;
    logic [7:0]    head;

    state_t        state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic          cfg_par_q, cfg_par_d;
    logic          cfg_8b_q, cfg_8b_d;
    logic          cfg_fast_q, cfg_fast_d;
    logic [12:0]   baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic          tx_q, tx_d;

    // A write to a full FIFO still lands when the FSM pops the same cycle.
    assign push = write_enable && (!full_q || pop);
    assign head = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            drop_q   <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == DEPTH_CNT);
            empty_q <= (count_d == '0);
            drop_q  <= write_enable && full_q && !pop;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        par_d      = par_q;
        cfg_par_d  = cfg_par_q;
        cfg_8b_d   = cfg_8b_q;
        cfg_fast_d = cfg_fast_q;
        bit_d      = bit_q;
        load       = 1'b0;
        pop        = 1'b0;
        bit_end    = (baud_q == (cfg_fast_q ? LAST_FAST : LAST_SLOW));

        case (state_q)
            S_IDLE: begin
                if (!empty_q) load = 1'b1;
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == {2'b11, cfg_8b_q}) begin
                        state_d = cfg_par_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) state_d = S_STOP;
            end
            S_STOP: begin
                if (bit_end) begin
                    if (!empty_q) load = 1'b1;
                    else          state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Frame config is captured together with the byte, so switch changes
        // only ever affect the next frame.
        if (load) begin
            pop        = 1'b1;
            state_d    = S_START;
            shift_d    = head;
            par_d      = ^(head & {SW1, 7'h7F});
            cfg_par_d  = SW0;
            cfg_8b_d   = SW1;
            cfg_fast_d = SW2;
        end

        baud_d = (bit_end || (state_d != state_q) || (state_q == S_IDLE))
                 ? 13'd0 : baud_q + 13'd1;

        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            par_q      <= 1'b0;
            cfg_par_q  <= 1'b0;
            cfg_8b_q   <= 1'b0;
            cfg_fast_q <= 1'b0;
            baud_q     <= '0;
            bit_q      <= '0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            cfg_par_q  <= cfg_par_d;
            cfg_8b_q   <= cfg_8b_d;
            cfg_fast_q <= cfg_fast_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            tx_q       <= tx_d;
        end
    end

    assign Tx       = tx_q;
    assign busy     = (state_q != S_IDLE);
    assign full     = full_q;
    assign empty    = empty_q;
    assign count    = count_q;
    assign drop_err = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for uart_tx: a frame-level model (byte queue + per-frame bit array)
// predicts every output each cycle; directed cases pin literal waveforms.
module tb_uart_tx;
    localparam int FAST  = 12;
    localparam int SLOW  = 40;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data_in;
    logic       write_enable;
    logic       sw0, sw1, sw2;
    logic       tx, busy, full, empty, drop_err;
    logic [3:0] count;

    uart_tx #(.CLKS_9600(SLOW), .CLKS_115200(FAST), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst_n), .data_in(data_in), .write_enable(write_enable),
        .SW0(sw0), .SW1(sw1), .SW2(sw2), .Tx(tx), .busy(busy), .full(full),
        .empty(empty), .count(count), .drop_err(drop_err)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] mq[$];
    bit  m_active = 1'b0;
    int  m_cyc = 0, m_len = 1, m_n = 1, m_sz;
    bit  m_bits[12];
    bit  m_drop = 1'b0, m_pop, m_acc;

    task automatic build_frame(input logic [7:0] b);
        int nd;
        bit p;
        nd = sw1 ? 8 : 7;
        p  = 1'b0;
        m_bits[0] = 1'b0;
        for (int i = 0; i < nd; i++) begin
            m_bits[1 + i] = b[i];
            p = p ^ b[i];
        end
        m_len = 1 + nd;
        if (sw0) begin
            m_bits[m_len] = p;
            m_len++;
        end
        m_bits[m_len] = 1'b1;
        m_len++;
        m_n = sw2 ? FAST : SLOW;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_active = 1'b0;
            m_cyc    = 0;
            m_drop   = 1'b0;
        end else begin
            m_sz  = mq.size();
            m_pop = 1'b0;
            if (!m_active) begin
                if (m_sz > 0) m_pop = 1'b1;
            end else if (m_cyc == m_len * m_n - 1) begin
                if (m_sz > 0) m_pop = 1'b1;
                else          m_active = 1'b0;
            end else begin
                m_cyc++;
            end
            m_acc  = write_enable && (m_sz < DEPTH || m_pop);
            m_drop = write_enable && (m_sz == DEPTH) && !m_pop;
            if (m_pop) begin
                build_frame(mq.pop_front());
                m_active = 1'b1;
                m_cyc    = 0;
            end
            if (m_acc) mq.push_back(data_in);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("tx_line", tx, m_active ? m_bits[m_cyc / m_n] : 1'b1);
            check("busy", busy, m_active);
            check("count", count, mq.size());
            check("full", full, mq.size() == DEPTH);
            check("empty", empty, mq.size() == 0);
            check("drop_err", drop_err, m_drop);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_sw(input logic [2:0] s);
        {sw2, sw1, sw0} = s;
    endtask

    task automatic send_and_capture(input logic [7:0] b, input int nb, input int n,
                                    output logic [15:0] bits, output int bcyc, output int lat);
        @(negedge clk);
        data_in = b;
        write_enable = 1'b1;
        @(negedge clk);
        write_enable = 1'b0;
        lat = 1;
        while (tx !== 1'b0 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        bits = '0;
        bcyc = 0;
        for (int k = 0; k < nb * n + n; k++) begin
            if ((k % n) == n / 2 && (k / n) < nb) bits[k / n] = tx;
            if (busy === 1'b1) bcyc++;
            @(negedge clk);
        end
    endtask

    task automatic count_busy(inout int c);
        int g = 0;
        while (busy === 1'b1 && g < 20000) begin
            @(negedge clk);
            g++;
            if (busy === 1'b1) c++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] bits;
        logic [7:0]  b;
        int bcyc, lat, nw, g;

        rst_n = 1'b0; write_enable = 1'b0; data_in = '0;
        sw0 = 1'b0; sw1 = 1'b0; sw2 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_count", count, 0);
        check("rst_drop", drop_err, 0);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        // 8N1 fast, 0x55
        set_sw(3'b110);
        send_and_capture(8'h55, 10, FAST, bits, bcyc, lat);
        check("8n1_latency", lat, 2);
        check("8n1_bits", bits, 16'h02AA);
        check("8n1_busy", bcyc, 10 * FAST);

        // 7E1 slow, 0xC1: bit 7 never sent, parity 0
        set_sw(3'b001);
        send_and_capture(8'hC1, 10, SLOW, bits, bcyc, lat);
        check("7e1_bits", bits, 16'h0282);
        check("7e1_busy", bcyc, 10 * SLOW);

        // 8E1 fast, 0x07: parity 1
        set_sw(3'b111);
        send_and_capture(8'h07, 11, FAST, bits, bcyc, lat);
        check("8e1_bits", bits, 16'h060E);
        check("8e1_parity", bits[9], 1);
        check("8e1_busy", bcyc, 11 * FAST);

        // Burst of 10 writes: 9 accepted, one drop, back-to-back frames
        set_sw(3'b110);
        bcyc = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy === 1'b1) bcyc++;
            if (i == 9) begin
                check("burst_count", count, 8);
                check("burst_full", full, 1);
            end
            data_in = 8'($urandom);
            write_enable = 1'b1;
        end
        @(negedge clk);
        write_enable = 1'b0;
        if (busy === 1'b1) bcyc++;
        check("burst_drop_pulse", drop_err, 1);
        @(negedge clk);
        if (busy === 1'b1) bcyc++;
        check("burst_drop_clear", drop_err, 0);
        count_busy(bcyc);
        check("burst_busy", bcyc, 90 * FAST);

        // Switch change mid-frame: frame 1 fast, frame 2 slow
        set_sw(3'b110);
        bcyc = 0;
        @(negedge clk); data_in = 8'hA5; write_enable = 1'b1;
        @(negedge clk); data_in = 8'h3C;
        @(negedge clk); write_enable = 1'b0;
        if (busy === 1'b1) bcyc++;
        repeat (3 * FAST) begin
            @(negedge clk);
            if (busy === 1'b1) bcyc++;
        end
        sw2 = 1'b0;
        count_busy(bcyc);
        check("sw_change_busy", bcyc, 10 * FAST + 10 * SLOW);

        // Reset during DATA with a byte still queued
        set_sw(3'b110);
        @(negedge clk); data_in = 8'($urandom); write_enable = 1'b1;
        @(negedge clk); data_in = 8'($urandom);
        @(negedge clk); write_enable = 1'b0;
        repeat (3 * FAST) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_tx", tx, 1);
        check("async_rst_busy", busy, 0);
        check("async_rst_empty", empty, 1);
        check("async_rst_count", count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        b = 8'($urandom);
        send_and_capture(b, 10, FAST, bits, bcyc, lat);
        check("post_rst_latency", lat, 2);
        check("post_rst_bits", bits, {6'b0, 1'b1, b, 1'b0});
        check("post_rst_busy", bcyc, 10 * FAST);

        // Randomized traffic with random switches, bursts and gaps
        for (int r = 0; r < 30; r++) begin
            @(negedge clk);
            {sw2, sw1, sw0} = 3'($urandom);
            nw = $urandom_range(1, 4);
            for (int w = 0; w < nw; w++) begin
                data_in = 8'($urandom);
                write_enable = 1'b1;
                @(negedge clk);
            end
            write_enable = 1'b0;
            repeat ($urandom_range(0, 250)) @(negedge clk);
        end
        g = 0;
        while ((busy !== 1'b0 || empty !== 1'b1) && g < 40000) begin
            @(negedge clk);
            g++;
        end
        check("drain_idle", {busy, empty, tx}, 3'b011);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
